// File: rtl/ascii_relation_parser.sv
// Byte-serial parser/checker for ASCII relation lines such as "21<129\n".
// Emits one result record per non-empty line over a valid/ready handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   GET_A | collecting operand A digits, waiting for the relation char
//   GET_B | collecting operand B digits, waiting for the terminator
//   SKIP  | line already in error, discarding up to the terminator
//   EMIT  | record presented on out_*, input stalled until transfer
module ascii_relation_parser #(
  parameter int CNT_W      = 16,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_a,
  output logic [7:0]       out_b,
  output logic [1:0]       out_op,
  output logic             out_true,
  output logic             out_err,
  output logic [1:0]       out_err_code,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam logic [DW-1:0] MAXD = DW'(MAX_DIGITS);

  localparam logic [1:0] OP_EQ = 2'b00;
  localparam logic [1:0] OP_LT = 2'b01;
  localparam logic [1:0] OP_GT = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_FORMAT  = 2'b10;
  localparam logic [1:0] ERR_RANGE   = 2'b11;

  typedef enum logic [1:0] {GET_A, GET_B, SKIP, EMIT} state_t;

  state_t           state, state_n;
  logic [9:0]       acc_a, acc_a_n;
  logic [9:0]       acc_b, acc_b_n;
  logic [DW-1:0]    cnt_a, cnt_a_n;
  logic [DW-1:0]    cnt_b, cnt_b_n;
  logic [1:0]       op, op_n;
  logic [1:0]       err_code, err_code_n;
  logic [CNT_W-1:0] ok_cnt, ok_cnt_n;
  logic [CNT_W-1:0] err_cnt, err_cnt_n;

  logic       take;
  logic       is_digit, is_op, is_term, is_space;
  logic [3:0] digit;
  logic [1:0] op_code;
  logic [9:0] acc_sel, acc_step;
  logic [DW-1:0] cnt_sel;
  logic [1:0] digit_err;
  logic [1:0] new_err;
  logic       emit, line_ok;

  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_op    = (in_data == 8'h3C) || (in_data == 8'h3D) || (in_data == 8'h3E);
  assign is_term  = (in_data == 8'h0A) || (in_data == 8'h0D);
  assign is_space = (in_data == 8'h20);
  assign digit    = in_data[3:0];

  always_comb begin
    op_code = OP_EQ;
    case (in_data)
      8'h3C:   op_code = OP_LT;
      8'h3E:   op_code = OP_GT;
      default: op_code = OP_EQ;
    endcase
  end

  // Digit count is checked before the value so an over-long operand reports a
  // format error. While count < MAX_DIGITS the accumulator is at most 99, so
  // the 10-bit step never wraps.
  assign acc_sel  = (state == GET_B) ? acc_b : acc_a;
  assign cnt_sel  = (state == GET_B) ? cnt_b : cnt_a;
  assign acc_step = (acc_sel << 3) + (acc_sel << 1) + {6'd0, digit};

  always_comb begin
    digit_err = ERR_NONE;
    if (cnt_sel >= MAXD)
      digit_err = ERR_FORMAT;
    else if (acc_step > 10'd255)
      digit_err = ERR_RANGE;
  end

  assign emit     = (state == EMIT);
  assign take     = in_valid && !emit;

  always_comb begin
    state_n    = state;
    acc_a_n    = acc_a;
    acc_b_n    = acc_b;
    cnt_a_n    = cnt_a;
    cnt_b_n    = cnt_b;
    op_n       = op;
    err_code_n = err_code;
    ok_cnt_n   = ok_cnt;
    err_cnt_n  = err_cnt;
    new_err    = ERR_NONE;

    case (state)
      GET_A: begin
        if (take && !is_space) begin
          if (is_digit) begin
            if (digit_err != ERR_NONE) begin
              new_err = digit_err;
              state_n = SKIP;
            end else begin
              acc_a_n = acc_step;
              cnt_a_n = cnt_a + DW'(1);
            end
          end else if (is_op) begin
            if (cnt_a != '0) begin
              op_n    = op_code;
              state_n = GET_B;
            end else begin
              new_err = ERR_FORMAT;
              state_n = SKIP;
            end
          end else if (is_term) begin
            // A bare terminator (blank line or CR of a CRLF pair) is dropped.
            if (cnt_a != '0) begin
              new_err = ERR_FORMAT;
              state_n = EMIT;
            end
          end else begin
            new_err = ERR_ILLEGAL;
            state_n = SKIP;
          end
        end
      end

      GET_B: begin
        if (take && !is_space) begin
          if (is_digit) begin
            if (digit_err != ERR_NONE) begin
              new_err = digit_err;
              state_n = SKIP;
            end else begin
              acc_b_n = acc_step;
              cnt_b_n = cnt_b + DW'(1);
            end
          end else if (is_term) begin
            if (cnt_b == '0)
              new_err = ERR_FORMAT;
            state_n = EMIT;
          end else if (is_op) begin
            new_err = ERR_FORMAT;
            state_n = SKIP;
          end else begin
            new_err = ERR_ILLEGAL;
            state_n = SKIP;
          end
        end
      end

      SKIP: begin
        if (take && is_term)
          state_n = EMIT;
      end

      EMIT: begin
        if (out_ready) begin
          if (err_code == ERR_NONE) begin
            if (ok_cnt != '1)
              ok_cnt_n = ok_cnt + CNT_W'(1);
          end else begin
            if (err_cnt != '1)
              err_cnt_n = err_cnt + CNT_W'(1);
          end
          acc_a_n    = '0;
          acc_b_n    = '0;
          cnt_a_n    = '0;
          cnt_b_n    = '0;
          op_n       = OP_EQ;
          err_code_n = ERR_NONE;
          state_n    = GET_A;
        end
      end

      default: state_n = GET_A;
    endcase

    // First error of a line is sticky.
    if ((new_err != ERR_NONE) && (err_code == ERR_NONE))
      err_code_n = new_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GET_A;
      acc_a    <= '0;
      acc_b    <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      op       <= OP_EQ;
      err_code <= ERR_NONE;
      ok_cnt   <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      acc_a    <= acc_a_n;
      acc_b    <= acc_b_n;
      cnt_a    <= cnt_a_n;
      cnt_b    <= cnt_b_n;
      op       <= op_n;
      err_code <= err_code_n;
      ok_cnt   <= ok_cnt_n;
      err_cnt  <= err_cnt_n;
    end
  end

  // Record fields are gated so nothing but zeros leaves the block outside EMIT
  // and error records carry no operand data.
  assign line_ok      = (err_code == ERR_NONE);
  assign in_ready     = !emit;
  assign out_valid    = emit;
  assign out_err      = emit && !line_ok;
  assign out_err_code = emit ? err_code : ERR_NONE;
  assign out_a        = (emit && line_ok) ? acc_a[7:0] : 8'd0;
  assign out_b        = (emit && line_ok) ? acc_b[7:0] : 8'd0;
  assign out_op       = (emit && line_ok) ? op : OP_EQ;

  always_comb begin
    out_true = 1'b0;
    if (emit && line_ok) begin
      case (op)
        OP_LT:   out_true = (acc_a < acc_b);
        OP_GT:   out_true = (acc_a > acc_b);
        default: out_true = (acc_a == acc_b);
      endcase
    end
  end

  assign ok_count  = ok_cnt;
  assign err_count = err_cnt;

endmodule

// File: tb/tb_ascii_relation_parser.sv
// Self-checking bench for ascii_relation_parser: table of lines with expected
// records feeding a scoreboard queue, plus stall and mid-line reset sequences.
module tb_ascii_relation_parser;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_a, out_b;
  logic [1:0]       out_op;
  logic             out_true, out_err;
  logic [1:0]       out_err_code;
  logic [CNT_W-1:0] ok_count, err_count;

  ascii_relation_parser #(.CNT_W(CNT_W), .MAX_DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_true(out_true),
    .out_err(out_err), .out_err_code(out_err_code),
    .ok_count(ok_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string line;
    bit    has_rec;
    int    a, b, op, tru, err, code;
  } vec_t;

  vec_t        vecs[$];
  logic [21:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_ok   = 0;
  int          exp_err  = 0;

  function automatic logic [21:0] pack_rec(int a, int b, int op, int tru, int err, int code);
    return {a[7:0], b[7:0], op[1:0], tru[0], err[0], code[1:0]};
  endfunction

  task automatic add_vec(string l, bit h, int a, int b, int op, int tru, int err, int code);
    vec_t v;
    v.line = l; v.has_rec = h;
    v.a = a; v.b = b; v.op = op; v.tru = tru; v.err = err; v.code = code;
    vecs.push_back(v);
  endtask

  task automatic check(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Scoreboard: a record transfers on the posedge following a negedge where
  // both valid and ready are high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [21:0] act;
      act = {out_a, out_b, out_op, out_true, out_err, out_err_code};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_record: got %h expected none", act);
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL record: got a=%0d b=%0d op=%0d t=%0d err=%0d code=%0d expected a=%0d b=%0d op=%0d t=%0d err=%0d code=%0d",
                   act[21:14], act[13:6], act[5:4], act[3], act[2], act[1:0],
                   e[21:14], e[13:6], e[5:4], e[3], e[2], e[1:0]);
        end
        if (e[2]) exp_err++;
        else      exp_ok++;
      end
    end
  end

  task automatic send_char(byte c);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid = 1'b1;
    in_data  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_line(string s);
    for (int i = 0; i < s.len(); i++)
      send_char(s[i]);
  endtask

  task automatic drain_and_check(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    check({name, "_ok_count"}, int'(ok_count), exp_ok);
    check({name, "_err_count"}, int'(err_count), exp_err);
  endtask

  initial begin
    add_vec("21<129\n",    1, 21, 129, 1, 1, 0, 0);
    add_vec("224 > 7\015", 1, 224, 7,  2, 1, 0, 0);
    add_vec("2>7\n",       1, 2,   7,  2, 0, 0, 0);
    add_vec("300>2\n",     1, 0,   0,  0, 0, 1, 3);
    add_vec("1x2\n",       1, 0,   0,  0, 0, 1, 1);
    add_vec("1234<5\n",    1, 0,   0,  0, 0, 1, 2);
    add_vec("9>2\n",       1, 9,   2,  2, 1, 0, 0);
    add_vec("0=0\n",       1, 0,   0,  0, 1, 0, 0);
    add_vec("255>254\n",   1, 255, 254, 2, 1, 0, 0);
    add_vec("<5\n",        1, 0,   0,  0, 0, 1, 2);
    add_vec("3<\n",        1, 0,   0,  0, 0, 1, 2);
    add_vec("\n\015\n",    0, 0,   0,  0, 0, 0, 0);
    add_vec("7=8\015\n",   1, 7,   8,  0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_fields", int'({out_a, out_b, out_op, out_true, out_err, out_err_code}), 0);
    check("reset_counts", int'(ok_count) + int'(err_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", int'(in_ready), 1);

    foreach (vecs[i]) begin
      if (vecs[i].has_rec)
        exp_q.push_back(pack_rec(vecs[i].a, vecs[i].b, vecs[i].op,
                                 vecs[i].tru, vecs[i].err, vecs[i].code));
      send_line(vecs[i].line);
      drain_and_check($sformatf("vec%0d", i));
      check($sformatf("vec%0d_idle_out_valid", i), int'(out_valid), 0);
    end
    check("table_err_total", exp_err, 5);

    // Downstream stall: record must hold with input blocked.
    out_ready = 1'b0;
    exp_q.push_back(pack_rec(5, 5, 0, 1, 0, 0));
    send_line("5=5\n");
    begin
      int ok_before;
      ok_before = int'(ok_count);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check("stall_out_valid", int'(out_valid), 1);
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_fields", int'({out_a, out_b, out_op, out_true, out_err}), int'({8'd5, 8'd5, 2'd0, 1'b1, 1'b0}));
        check("stall_ok_count", int'(ok_count), ok_before);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release_out_valid", int'(out_valid), 0);
      check("release_in_ready", int'(in_ready), 1);
      check("release_ok_count", int'(ok_count), ok_before + 1);
    end
    drain_and_check("stall");

    // Reset in the middle of a line.
    send_line("12<3");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", int'(in_ready), 1);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_ok_count", int'(ok_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ok  = 0;
    exp_err = 0;
    exp_q.delete();
    exp_q.push_back(pack_rec(4, 9, 1, 1, 0, 0));
    send_line("4<9\n");
    drain_and_check("after_reset");
    repeat (5) @(negedge clk);
    check("final_out_valid", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ascii_relation_parser.md
Name: ascii_relation_parser

Overview:
- Byte-serial consumer of ASCII comparison text of the form "A op B" + terminator, e.g. "21<129\n".
- Parses two decimal operands (0..255) and one relation character ('<', '=', '>').
- Checks whether the stated relation actually holds, then emits one result record per line over a valid/ready handshake.
- Sits downstream of the comparator text stream (UART/log capture path) as its reader and checker.

Parameters:
CNT_W, 16, width of the saturating ok/error line counters
MAX_DIGITS, 3, maximum decimal digits per operand

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  8  ASCII character
in_valid  input  1  in_data valid
in_ready  output  1  parser accepts in_data this cycle
out_valid  output  1  result record valid
out_ready  input  1  downstream accepts record
out_a  output  8  parsed operand A
out_b  output  8  parsed operand B
out_op  output  2  relation code: 00 '=', 01 '<', 10 '>'
out_true  output  1  stated relation holds for (A, B)
out_err  output  1  line was malformed
out_err_code  output  2  00 none, 01 illegal char, 10 format, 11 range
ok_count  output  CNT_W  well-formed lines emitted, saturating
err_count  output  CNT_W  malformed lines emitted, saturating

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous and active-low.
- Reset values:
  - all outputs 0 except in_ready=1
  - state=GET_A, accumulators, digit counts and latched error cleared
- Transfer rules:
  - Input transfer occurs when in_valid&&in_ready.
  - Output transfer occurs when out_valid&&out_ready.
- Character classes:
  - digit 0x30-0x39
  - op '<' 0x3C, '=' 0x3D, '>' 0x3E
  - terminator LF 0x0A or CR 0x0D
  - space 0x20 is ignored in every state except SKIP, where it is discarded
  - anything else is illegal
- Accumulator: acc = acc*10 + digit, held in 10 bits. Value >255 latches range error (11). Digit count >MAX_DIGITS latches format error (10).
- States:
  - GET_A:
    - digit → accumulate A.
    - op with ≥1 A digit → latch op, go GET_B.
    - op with 0 digits → format error.
    - terminator with no characters since line start → ignored (empty line), stay.
    - terminator otherwise → format error, go EMIT.
    - illegal char → illegal error.
  - GET_B:
    - digit → accumulate B.
    - terminator with ≥1 B digit → go EMIT.
    - terminator with 0 digits → format error, go EMIT.
    - second op → format error.
    - illegal char → illegal error.
  - SKIP:
    - Entered on any error that is not itself a terminator.
    - Discards characters until a terminator, then goes to EMIT.
  - EMIT:
    - out_valid=1, in_ready=0.
    - Record fields are stable until transfer.
    - On transfer: out_valid→0, increment ok_count or err_count (saturate at all-ones), clear line state, go GET_A.
- Error priority: first error in a line wins; later errors in the same line do not overwrite out_err_code.
- out_true:
  - (A==B) for '=', (A<B) for '<', (A>B) for '>'.
  - Compared unsigned.
- Error records: out_err=1 and out_err_code set; out_a, out_b, out_op and out_true are forced to 0.
- Latency: terminator accepted at edge N → out_valid=1 after edge N. Minimum one idle input cycle per line, because in_ready=0 in EMIT.
- Downstream stall: out_ready=0 holds EMIT indefinitely. in_ready stays 0, so no input is lost.
- Reset mid-line or mid-EMIT: partial line or pending record discarded. Counters cleared.

Test Plan:
- "21<129\n" → one record: out_a=21, out_b=129, out_op=01, out_true=1, out_err=0; ok_count=1.
- "224 > 7\r" then "2>7\n" → records: {224,7,10,true=1}, then {2,7,10,true=0}; the spaces in the first line are ignored.
- "5=5\n" with out_ready held low 4 cycles → out_valid stays 1, in_ready stays 0, fields stable. On release the transfer occurs in one cycle and ok_count increments by 1.
- "300>2\n" → out_err=1, code 11, fields 0. Then "1x2\n" → code 01. Then "1234<5\n" → code 10. err_count=3; the following "9>2\n" is accepted with ok.
- Boundaries:
  - "0=0\n" → true=1.
  - "255>254\n" → true=1.
  - "<5\n" → code 10.
  - "3<\n" → code 10.
  - "\n\r\n" alone → no records.
- Assert rst_n low mid-"12<3" then release and send "4<9\n" → exactly one record {4,9,01,1}, counters reflect only the post-reset line.
